// File: rtl/fifo_burst_reader_pkg.sv
// fifo_burst_reader_pkg: shared types and sizes for the FIFO burst reader.
package fifo_burst_reader_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int BUF_DEPTH = 2;
    localparam int STALL_W = 16;
endpackage

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: command, FIFO read port and output stream of the burst reader.
interface fifo_burst_reader_if #(parameter int WIDTH = 16, parameter int LEN_W = 8);
    import fifo_burst_reader_pkg::*;
    logic start;
    logic [LEN_W-1:0] burst_len;
    logic busy;
    logic done;
    logic fifo_empty;
    logic fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout;
    logic m_valid;
    logic m_ready;
    logic [WIDTH-1:0] m_data;
    logic m_last;
    logic [STALL_W-1:0] stall_cnt;
    modport master (
        input start, burst_len, fifo_empty, fifo_dout, m_ready,
        output busy, done, fifo_rd_en, m_valid, m_data, m_last, stall_cnt
    );
    modport slave (
        output start, burst_len, fifo_empty, fifo_dout, m_ready,
        input busy, done, fifo_rd_en, m_valid, m_data, m_last, stall_cnt
    );
endinterface

// File: rtl/fifo_burst_reader_buf2.sv
// fifo_burst_reader_buf2: two-entry in-order buffer absorbing the FIFO read latency.
module fifo_burst_reader_buf2
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [BUF_DEPTH];
    assign head = mem[0];
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            occ <= '0;
        end else begin
            occ <= occ + {1'b0, wr_en} - {1'b0, pop};
            // on pop the tail shifts to the head; an incoming word lands behind whatever remains
            if (pop) begin
                mem[0] <= (occ == 2'd2) ? mem[1] : wr_data;
                if (wr_en) mem[1] <= wr_data;
            end else if (wr_en) begin
                mem[occ[0]] <= wr_data;
            end
        end
    end
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops burst_len FIFO words onto a valid/ready stream with m_last.
// Define FIFO_BURST_READER_STATS_EN to build the saturating consumer-stall counter.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input logic clk,
    input logic reset,
    fifo_burst_reader_if.master bus
);
    state_t state, state_n;
    logic [LEN_W-1:0] len_q, issued, accepted;
    logic inflight, pop, rd_en, launch, last_pop;
    logic [1:0] occ;
    logic [WIDTH-1:0] head;
    assign pop = bus.m_valid & bus.m_ready;
    assign launch = (state == IDLE) && bus.start && (bus.burst_len != '0);
    assign last_pop = pop && (accepted == len_q - 1'b1);
    // the word already in flight still needs a slot, so count it against the buffer
    assign rd_en = !reset && (state == RUN) && !bus.fifo_empty && (issued < len_q) &&
                   (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    assign bus.fifo_rd_en = rd_en;
    assign bus.busy = state != IDLE;
    assign bus.done = !reset && (state == DRAIN) && last_pop;
    assign bus.m_valid = occ != 2'd0;
    assign bus.m_data = head;
    assign bus.m_last = bus.m_valid && (accepted == len_q - 1'b1);
    always_comb begin
        state_n = state;
        if (launch) state_n = RUN;
        if (state == RUN && rd_en && issued == len_q - 1'b1) state_n = DRAIN;
        if (state == DRAIN && last_pop) state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            len_q <= '0;
            issued <= '0;
            accepted <= '0;
            inflight <= 1'b0;
        end else begin
            state <= state_n;
            inflight <= rd_en;
            if (launch) begin
                len_q <= bus.burst_len;
                issued <= '0;
                accepted <= '0;
            end else begin
                issued <= issued + LEN_W'(rd_en);
                accepted <= accepted + LEN_W'(pop);
            end
        end
    end
    fifo_burst_reader_buf2 #(.WIDTH(WIDTH)) u_buf (
        .clk(clk),
        .reset(reset),
        .wr_en(inflight),
        .wr_data(bus.fifo_dout),
        .pop(pop),
        .occ(occ),
        .head(head)
    );
`ifdef FIFO_BURST_READER_STATS_EN
    logic [STALL_W-1:0] stall_q;
    always_ff @(posedge clk) begin
        if (reset) stall_q <= '0;
        else if (bus.m_valid && !bus.m_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side controller for the team's synchronous FIFO.
- On a start command, pops exactly burst_len words from the FIFO read port and presents them on a valid/ready output stream, flagging the final beat with m_last.
- Absorbs the FIFO's 1-cycle read latency in a 2-entry output buffer, so a stalled consumer never loses data.
- Sits between the FIFO and downstream packet/serializer logic.

Parameters:
WIDTH, 16, data word width; must match the FIFO's WIDTH.
LEN_W, 8, width of burst_len; maximum burst is 2^LEN_W-1 words.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
start  input  1  request a burst; sampled only in IDLE.
burst_len  input  LEN_W  words in the burst; sampled with start.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse when the last beat is accepted.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_en  output  1  FIFO read request; combinational.
fifo_dout  input  WIDTH  FIFO read data; valid on the cycle after fifo_rd_en.
m_valid  output  1  output beat valid.
m_ready  input  1  consumer accepts the beat.
m_data  output  WIDTH  output beat data.
m_last  output  1  final beat of the burst; qualified by m_valid.
stall_cnt  output  16  consumer-stall counter (see Optional Feature).

Behaviour:
- Reset values: busy=0, done=0, m_valid=0, m_data=0, m_last=0, stall_cnt=0. fifo_rd_en is 0 during reset. State goes to IDLE; both counters and the output buffer are cleared.
- States and transitions:
  - IDLE -> RUN when start=1 and burst_len!=0. burst_len is latched into len_q; issued and accepted counters are zeroed.
  - start with burst_len=0 is ignored and done stays 0.
  - RUN -> DRAIN on the cycle the len_q-th read is issued.
  - DRAIN -> IDLE on the cycle the len_q-th beat is accepted; done=1 for that single cycle.
  - start is ignored outside IDLE.
- pop = m_valid & m_ready.
- inflight = registered copy of fifo_rd_en from the previous cycle.
- occ = output buffer occupancy, 0 to 2.
- Read issue: fifo_rd_en = (state==RUN) & !fifo_empty & (issued<len_q) & (occ+inflight-pop < 2).
  - Never issue a read while fifo_empty=1.
  - Never overflow the buffer.
- Buffer write: when inflight=1, fifo_dout is written into the buffer at the clock edge. Simultaneous write and pop is legal.
- Ordering: beats leave in FIFO order.
- m_data and m_valid are driven from buffer entry 0. They must hold stable while m_valid & !m_ready.
- m_last = m_valid & (accepted == len_q-1).
- Latency: start in cycle 0 with the FIFO non-empty gives fifo_rd_en in cycle 1 and m_valid in cycle 3.
- Throughput: 1 beat per cycle sustained while fifo_empty=0 and m_ready=1.
- Consumer stall: with m_ready=0, reads stop once occ+inflight reaches 2. They resume the cycle a pop frees a slot.
- FIFO runs empty mid-burst: stay in RUN with no reads and no timeout; continue when fifo_empty drops.
- Counters are LEN_W bits wide and never wrap, since issued and accepted are both ≤ len_q.
- Reset mid-burst: abort immediately. In-flight FIFO data is discarded, done is not pulsed, and the system resets the FIFO together with this block.

Optional Feature:
- Macro FIFO_BURST_READER_STATS_EN.
- Defined: stall_cnt increments every cycle with m_valid & !m_ready. It saturates at 16'hFFFF, clears on reset, and is not cleared by start.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package fifo_burst_reader_pkg:
  - state enum {IDLE, RUN, DRAIN};
  - localparam BUF_DEPTH=2;
  - stall counter width, 16.
- Sub-module fifo_burst_reader_buf2: 2-entry in-order buffer with wr_en/wr_data, pop, occ, head data, and its own synchronous reset.
- The top level holds the FSM, counters, read-issue logic and the stats counter.

Test Plan:
- FIFO preloaded with 0x0001..0x0004, burst_len=4, m_ready=1 -> fifo_rd_en in cycles 1-4; m_data 0x0001..0x0004 in cycles 3-6; m_last only with 0x0004; done in cycle 6; busy low from cycle 7.
- burst_len=3, m_ready held 0 for 10 cycles after start -> exactly 2 reads issued; m_data=first word held stable; on release, 3 beats in order with no loss or duplication.
- FIFO holds 1 word, burst_len=3, then 2 more words written 8 cycles later -> RUN persists with fifo_rd_en=0 while empty; burst completes with all 3 words; done pulses once.
- start with burst_len=0 -> state stays IDLE; fifo_rd_en, done and busy stay 0. Then start burst_len=2 while busy -> second start ignored; exactly 2 beats are produced.
- Reset asserted the cycle after the 2nd read of a 5-word burst -> next cycle m_valid=0, busy=0, fifo_rd_en=0, no done. A fresh burst afterwards works normally.
- With FIFO_BURST_READER_STATS_EN defined, m_valid high and m_ready low for 7 cycles -> stall_cnt=7. Without the macro -> stall_cnt=0.
